// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage and EX/MEM pipeline latch of the 5-stage MIPS core.
//
// The stage selects the forwarded operands and decodes the ALU operation. It computes
// the ALU result, the branch target and the destination register. All results are
// registered here. The memory stage consumes the registered outputs directly.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   ctrl_clk_mips       pipeline enable from the debug unit (0 = hold all state)
//   flush               squash the control of the instruction entering the latch
//   in_pc_plus4         PC+4 of the instruction in EX
//   read_data_1/2       rs / rt values from the register file
//   sign_ext_imm        sign-extended immediate (funct field in bits [5:0])
//   in_rt, in_rd        candidate destination register indices
//   shamt               shift amount field
//   alu_op              ALU class from the control unit
//   ex_bus              [0] ALUSrc, [1] RegDst
//   in_memory_bus       memory controls (passed through)
//   in_writeBack_bus    write-back controls (passed through)
//   halt_flag_e         HALT reached EX
//   fwd_a, fwd_b        forwarding selects for operands A / B
//   fwd_mem_data        value forwarded from the memory stage
//   fwd_wb_data         value forwarded from the write-back stage
//   out_*               registered results for the memory stage
module ex_mem_stage #(
    parameter int unsigned len_data    = 32,
    parameter int unsigned num_bits    = 5,
    parameter int unsigned len_mem_bus = 9,
    parameter int unsigned len_wb_bus  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctrl_clk_mips,
    input  logic                   flush,
    input  logic [len_data-1:0]    in_pc_plus4,
    input  logic [len_data-1:0]    read_data_1,
    input  logic [len_data-1:0]    read_data_2,
    input  logic [len_data-1:0]    sign_ext_imm,
    input  logic [num_bits-1:0]    in_rt,
    input  logic [num_bits-1:0]    in_rd,
    input  logic [4:0]             shamt,
    input  logic [2:0]             alu_op,
    input  logic [1:0]             ex_bus,
    input  logic [len_mem_bus-1:0] in_memory_bus,
    input  logic [len_wb_bus-1:0]  in_writeBack_bus,
    input  logic                   halt_flag_e,
    input  logic [1:0]             fwd_a,
    input  logic [1:0]             fwd_b,
    input  logic [len_data-1:0]    fwd_mem_data,
    input  logic [len_data-1:0]    fwd_wb_data,
    output logic [len_data-1:0]    out_addr_mem,
    output logic [len_data-1:0]    out_write_data,
    output logic [len_mem_bus-1:0] out_memory_bus,
    output logic [len_wb_bus-1:0]  out_writeBack_bus,
    output logic [num_bits-1:0]    out_write_reg,
    output logic                   zero_flag,
    output logic [len_data-1:0]    out_pc_branch,
    output logic                   out_halt_flag_m
);

    logic [len_data-1:0] op_a, op_b_st, op_b, op_b_logic, alu_result;
    logic [len_data-1:0] pc_branch_d;
    logic [num_bits-1:0] write_reg_d;
    logic                alu_src, reg_dst;

    assign alu_src = ex_bus[0];
    assign reg_dst = ex_bus[1];

    // Selects 00 and 11 both fall back to the register file value.
    always_comb begin
        unique case (fwd_a)
            2'b01:   op_a = fwd_mem_data;
            2'b10:   op_a = fwd_wb_data;
            default: op_a = read_data_1;
        endcase
        unique case (fwd_b)
            2'b01:   op_b_st = fwd_mem_data;
            2'b10:   op_b_st = fwd_wb_data;
            default: op_b_st = read_data_2;
        endcase
    end

    assign op_b = alu_src ? sign_ext_imm : op_b_st;
    // andi/ori/xori zero-extend their immediate instead of sign-extending it.
    assign op_b_logic = alu_src ? {{(len_data-16){1'b0}}, sign_ext_imm[15:0]} : op_b_st;

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            3'b000: alu_result = op_a + op_b;
            3'b001: alu_result = op_a - op_b;
            3'b010: begin
                case (sign_ext_imm[5:0])
                    6'h00:         alu_result = op_b << shamt;
                    6'h02:         alu_result = op_b >> shamt;
                    6'h03:         alu_result = $signed(op_b) >>> shamt;
                    6'h04:         alu_result = op_b << op_a[4:0];
                    6'h06:         alu_result = op_b >> op_a[4:0];
                    6'h07:         alu_result = $signed(op_b) >>> op_a[4:0];
                    6'h20, 6'h21:  alu_result = op_a + op_b;
                    6'h22, 6'h23:  alu_result = op_a - op_b;
                    6'h24:         alu_result = op_a & op_b;
                    6'h25:         alu_result = op_a | op_b;
                    6'h26:         alu_result = op_a ^ op_b;
                    6'h27:         alu_result = ~(op_a | op_b);
                    6'h2A:         alu_result = {{(len_data-1){1'b0}},
                                                 $signed(op_a) < $signed(op_b)};
                    default:       alu_result = '0;
                endcase
            end
            3'b011: alu_result = op_a & op_b_logic;
            3'b100: alu_result = op_a | op_b_logic;
            3'b101: alu_result = op_a ^ op_b_logic;
            3'b110: alu_result = {op_b[15:0], {(len_data-16){1'b0}}};
            3'b111: alu_result = {{(len_data-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_result = '0;
        endcase
    end

    assign pc_branch_d = in_pc_plus4 + (sign_ext_imm << 2);
    assign write_reg_d = reg_dst ? in_rd : in_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr_mem      <= '0;
            out_write_data    <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
            out_write_reg     <= '0;
            zero_flag         <= 1'b0;
            out_pc_branch     <= '0;
            out_halt_flag_m   <= 1'b0;
        end else if (ctrl_clk_mips) begin
            out_addr_mem   <= alu_result;
            out_write_data <= op_b_st;
            out_write_reg  <= write_reg_d;
            zero_flag      <= (alu_result == '0);
            out_pc_branch  <= pc_branch_d;
            // A flushed instruction keeps its data but loses every side effect.
            if (flush) begin
                out_memory_bus    <= '0;
                out_writeBack_bus <= '0;
                out_halt_flag_m   <= 1'b0;
            end else begin
                out_memory_bus    <= in_memory_bus;
                out_writeBack_bus <= in_writeBack_bus;
                out_halt_flag_m   <= halt_flag_e;
            end
        end
    end

endmodule
